fp_mul_normalize: RTL and testbench
===================================

# fp_mul_normalize

Final stage of the pipelined floating-point multiplier. Consumes the 48-bit mantissa product from the multiply array together with the sign, raw operands and exponents delayed to match it. Normalizes, rounds to nearest-even, handles IEEE-754 single-precision special cases, and packs the 32-bit result. Two-stage valid/ready pipeline with global stall.

## Interface
- BIAS, 127, exponent bias.
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- s  input  1  result sign (already XOR of operand signs).
- a, b  input  32  raw operands, delayed to align with p.
- e1, e2  input  8  biased exponents of a, b, delayed to align with p.
- p  input  48  unsigned product of the 24-bit significands (hidden bits included).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  32  packed single-precision product.
- overflow, underflow, invalid  output  1 each  exception flags, qualified by out_valid.

## Operation
- Input class, per operand: zero/denormal (exp==0, flushed to zero), inf (exp==255, frac==0), NaN (exp==255, frac!=0).
- Priority: any NaN -> 32'h7FC00000, invalid=0; inf × zero -> 32'h7FC00000, invalid=1; inf × finite nonzero -> {s,8'hFF,23'h0}; zero × finite -> {s,31'h0}.
- Finite path, stage 1: exponent sum E = e1+e2-BIAS as 10-bit signed. If p[47]=1: sig=p[47:24], guard=p[23], sticky=|p[22:0], E=E+1. Else: sig=p[46:23], guard=p[22], sticky=|p[21:0].
- Stage 2 rounding: increment sig when guard & (sticky | sig[0]). If increment carries out of 24 bits, sig=24'h800000 and E=E+1.
- Post-round: E≥255 -> {s,8'hFF,23'h0}, overflow=1. E≤0 -> {s,31'h0}, underflow=1 (no denormal output). Else {s,E[7:0],sig[22:0]}.
- Flags are mutually exclusive; all 0 on special-case results except invalid as stated.

## Timing
- Latency 2 cycles: beat accepted at edge N appears on result at edge N+2 when no stall.
- Throughput one beat/cycle.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. During stall both stage registers, result, flags and out_valid hold; input ignored.
- Bubbles (in_valid=0) propagate as out_valid=0; data registers may hold stale values, only valid is meaningful.
- Beat transfers out when out_valid & out_ready at a rising edge.
- Reset: clear asserted at any time (including mid-operation or mid-stall) immediately forces both valid bits, out_valid, result and all flags to 0; in-flight beats are discarded. First acceptance on first edge after clear deasserts.
- Upstream delay line has no back-pressure; when integrated without stall, out_ready tied to 1.

## Structure
- Shared package fp_mul_pkg: BIAS, QNAN (32'h7FC00000), POS_INF exponent 8'hFF, operand-class enum {ZERO, NORMAL, INF, NAN}.
- One sub-module natural: fp_round_pack (combinational stage-2 rounding, overflow/underflow, packing); stage registers and handshake stay in the top.

## Test plan
- a=3FC00000, b=40000000, e1=127, e2=128, p=48'h600000000000, s=0 -> result 40400000 two cycles later, all flags 0.
- a=b=3F800001, e1=e2=127, p=48'h400001000001 -> result 3F800002 (guard=0, sticky=1, no round-up).
- a=b=7F000000, e1=e2=254, p=48'h400000000000 -> result 7F800000, overflow=1; a=b=00800000 (e=1), p=48'h400000000000 -> result 00000000, underflow=1.
- a=7F800000 × b=00000000 -> 7FC00000, invalid=1; a=7FC00000 × b=3F800000 -> 7FC00000, invalid=0; a=FF800000 × b=40000000, s=1 -> FF800000.
- Back-to-back stream of 4 beats, out_ready low for 3 cycles mid-stream -> in_ready low, result/out_valid held, no beat lost or duplicated, order preserved.
- Assert clear while 2 beats in flight -> out_valid and result 0 immediately (before next edge); after release, a new beat emerges exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined single-precision multiplier.
//   BIAS        : IEEE-754 single-precision exponent bias
//   QNAN        : canonical quiet NaN returned for NaN / invalid results
//   EXP_INF     : all-ones exponent used for infinities
//   op_class_t  : operand classification (denormals are flushed to ZERO)
//   stage1_t    : payload carried between the two normalize pipeline stages
//   classify()  : operand classification from biased exponent and fraction
package fp_mul_pkg;

    localparam int unsigned BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } op_class_t;

    // special=1 means special_res/special_inv are the final answer and the
    // finite fields (expo/sig/guard/sticky) are ignored by the rounder.
    typedef struct packed {
        logic               special;
        logic               special_inv;
        logic [31:0]        special_res;
        logic               sign;
        logic signed [9:0]  expo;
        logic [23:0]        sig;
        logic               guard;
        logic               sticky;
    } stage1_t;

    function automatic op_class_t classify(input logic [7:0] e, input logic [22:0] frac);
        op_class_t c;
        if (e == 8'h00) begin
            c = ZERO;
        end else if (e == EXP_INF) begin
            c = (frac == '0) ? INF : NAN;
        end else begin
            c = NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_mul_normalize_if.sv
// Handshake and data bundle between the multiply array and the normalize stage.
//   in_valid/in_ready    : upstream beat handshake
//   s, a, b, e1, e2, p   : sign, raw operands, biased exponents, 48-bit product
//   out_valid/out_ready  : downstream result handshake
//   result               : packed single-precision product
//   overflow/underflow/invalid : exception flags, qualified by out_valid
// slave  : view of the normalize stage
// master : view of the surrounding datapath (producer and consumer)
interface fp_mul_normalize_if;

    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [47:0] p;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    modport slave (
        input  in_valid, s, a, b, e1, e2, p, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid
    );

    modport master (
        output in_valid, s, a, b, e1, e2, p, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid
    );

endinterface

// File: rtl/fp_round_pack.sv
// Combinational second half of normalization: round-to-nearest-even,
// exponent range check and packing of the single-precision result.
//   st        : stage-1 payload (special result or normalized sig/guard/sticky)
//   result    : packed 32-bit result
//   overflow  : finite result exceeded the exponent range (returns +/-inf)
//   underflow : finite result below the normal range (returns +/-0)
//   invalid   : inf x zero
module fp_round_pack
    import fp_mul_pkg::*;
(
    input  stage1_t     st,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    logic              round_up;
    logic              carry;
    logic [22:0]       mant;
    logic signed [9:0] expo_r;

    // A carry out of the 24-bit significand can only happen when it is all
    // ones; the mantissa field then wraps to zero, which is exactly 1.0 x 2.
    assign round_up = st.guard & (st.sticky | st.sig[0]);
    assign carry    = (&st.sig) & round_up;
    assign mant     = st.sig[22:0] + {22'b0, round_up};
    assign expo_r   = carry ? (st.expo + 10'sd1) : st.expo;

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        invalid   = 1'b0;
        if (st.special) begin
            result  = st.special_res;
            invalid = st.special_inv;
        end else if (expo_r >= 10'sd255) begin
            result   = {st.sign, EXP_INF, 23'h0};
            overflow = 1'b1;
        end else if (expo_r <= 10'sd0) begin
            result    = {st.sign, 31'h0};
            underflow = 1'b1;
        end else begin
            result = {st.sign, expo_r[7:0], mant};
        end
    end

endmodule

// File: rtl/fp_mul_normalize.sv
// Final stage of the pipelined floating-point multiplier: classifies the
// operands, normalizes the 48-bit significand product, rounds to nearest-even
// and packs the single-precision result. Two register stages with a global
// stall driven by the downstream ready.
//   clk   : rising-edge clock
//   clear : asynchronous active-high reset, discards in-flight beats
//   bus   : fp_mul_normalize_if.slave (input beat, output result and flags)
module fp_mul_normalize #(
    parameter int unsigned BIAS = fp_mul_pkg::BIAS
) (
    input  logic             clk,
    input  logic             clear,
    fp_mul_normalize_if.slave bus
);

    import fp_mul_pkg::*;

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    op_class_t         cls_a;
    op_class_t         cls_b;
    logic signed [9:0] exp_sum;
    stage1_t           st1_d;
    stage1_t           st1_q;
    logic              v1_q;
    logic              stall;

    logic              out_valid_q;
    logic [31:0]       result_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              invalid_q;

    logic [31:0]       rp_result;
    logic              rp_overflow;
    logic              rp_underflow;
    logic              rp_invalid;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    assign cls_a   = classify(bus.e1, bus.a[22:0]);
    assign cls_b   = classify(bus.e2, bus.b[22:0]);
    assign exp_sum = $signed({2'b00, bus.e1}) + $signed({2'b00, bus.e2}) - BIAS_S;

    // Stage 1: special-case resolution in priority order, plus leading-one
    // alignment of the product (it is either in bit 47 or bit 46).
    always_comb begin
        st1_d      = '0;
        st1_d.sign = bus.s;
        if (bus.p[47]) begin
            st1_d.sig    = bus.p[47:24];
            st1_d.guard  = bus.p[23];
            st1_d.sticky = |bus.p[22:0];
            st1_d.expo   = exp_sum + 10'sd1;
        end else begin
            st1_d.sig    = bus.p[46:23];
            st1_d.guard  = bus.p[22];
            st1_d.sticky = |bus.p[21:0];
            st1_d.expo   = exp_sum;
        end

        if (cls_a == NAN || cls_b == NAN) begin
            st1_d.special     = 1'b1;
            st1_d.special_res = QNAN;
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            st1_d.special     = 1'b1;
            st1_d.special_inv = 1'b1;
            st1_d.special_res = QNAN;
        end else if (cls_a == INF || cls_b == INF) begin
            st1_d.special     = 1'b1;
            st1_d.special_res = {bus.s, EXP_INF, 23'h0};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            st1_d.special     = 1'b1;
            st1_d.special_res = {bus.s, 31'h0};
        end
    end

    fp_round_pack u_round_pack (
        .st        (st1_q),
        .result    (rp_result),
        .overflow  (rp_overflow),
        .underflow (rp_underflow),
        .invalid   (rp_invalid)
    );

    // Both stages advance together; a stall freezes the whole pipe.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            v1_q        <= 1'b0;
            st1_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else if (!stall) begin
            v1_q        <= bus.in_valid;
            if (bus.in_valid) begin
                st1_q <= st1_d;
            end
            out_valid_q <= v1_q;
            result_q    <= rp_result;
            overflow_q  <= rp_overflow;
            underflow_q <= rp_underflow;
            invalid_q   <= rp_invalid;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.invalid   = invalid_q;

endmodule

// File: tb/tb_fp_mul_normalize.sv
module tb_fp_mul_normalize;

    typedef struct packed {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [47:0] p;
    } beat_t;

    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic        inv;
        logic [31:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned nout   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_mul_normalize_if dut_if ();

    fp_mul_normalize #(.BIAS(127)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (dut_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic beat_t mk(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input logic [47:0] p);
        beat_t bt;
        bt.s  = s;
        bt.a  = a;
        bt.b  = b;
        bt.e1 = a[30:23];
        bt.e2 = b[30:23];
        bt.p  = p;
        return bt;
    endfunction

    function automatic exp_t ex(input logic ovf, input logic unf, input logic inv, input logic [31:0] res);
        exp_t e;
        e.ovf = ovf;
        e.unf = unf;
        e.inv = inv;
        e.res = res;
        return e;
    endfunction

    // Reference: integer shift/remainder rounding on the raw product.
    function automatic exp_t model(input beat_t bt);
        exp_t r;
        int ev;
        int sh;
        longint unsigned pp, sig, rem, half;
        bit an, ai, az, bn, bi, bz;
        r  = '0;
        an = (bt.e1 == 8'hFF) && (bt.a[22:0] != 23'h0);
        ai = (bt.e1 == 8'hFF) && (bt.a[22:0] == 23'h0);
        az = (bt.e1 == 8'h00);
        bn = (bt.e2 == 8'hFF) && (bt.b[22:0] != 23'h0);
        bi = (bt.e2 == 8'hFF) && (bt.b[22:0] == 23'h0);
        bz = (bt.e2 == 8'h00);
        if (an || bn) begin
            r.res = 32'h7FC00000;
        end else if ((ai && bz) || (bi && az)) begin
            r.res = 32'h7FC00000;
            r.inv = 1'b1;
        end else if (ai || bi) begin
            r.res = {bt.s, 8'hFF, 23'h0};
        end else if (az || bz) begin
            r.res = {bt.s, 31'h0};
        end else begin
            pp   = 64'(bt.p);
            sh   = bt.p[47] ? 24 : 23;
            ev   = int'(bt.e1) + int'(bt.e2) - 127 + (bt.p[47] ? 1 : 0);
            sig  = pp >> sh;
            half = 64'd1 << (sh - 1);
            rem  = pp & ((64'd1 << sh) - 64'd1);
            if (rem > half || (rem == half && sig[0])) sig++;
            if (sig == (64'd1 << 24)) begin
                sig = sig >> 1;
                ev++;
            end
            if (ev >= 255) begin
                r.res = {bt.s, 8'hFF, 23'h0};
                r.ovf = 1'b1;
            end else if (ev <= 0) begin
                r.res = {bt.s, 31'h0};
                r.unf = 1'b1;
            end else begin
                r.res = {bt.s, 8'(ev), sig[22:0]};
            end
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        logic [22:0] fa, fb;
        logic [7:0]  ea, eb;
        logic        sa, sbit;
        fa   = 23'($urandom);
        fb   = 23'($urandom);
        ea   = 8'($urandom_range(100, 154));
        eb   = 8'($urandom_range(100, 154));
        sa   = 1'($urandom);
        sbit = 1'($urandom);
        return mk(sa ^ sbit, {sa, ea, fa}, {sbit, eb, fb}, 48'({1'b1, fa}) * 48'({1'b1, fb}));
    endfunction

    task automatic drive(input beat_t bt);
        dut_if.s  = bt.s;
        dut_if.a  = bt.a;
        dut_if.b  = bt.b;
        dut_if.e1 = bt.e1;
        dut_if.e2 = bt.e2;
        dut_if.p  = bt.p;
    endtask

    // Present a beat until accepted; expectation is queued at acceptance.
    task automatic send(input beat_t bt, input exp_t e);
        bit acc;
        acc = 1'b0;
        drive(bt);
        dut_if.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut_if.in_ready) begin
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        dut_if.in_valid = 1'b0;
        if (!acc) check("send_accept_timeout", 64'(dut_if.in_ready), 64'd1);
    endtask

    // Single beat into an empty pipe with exact latency checks.
    task automatic beat_latency(input string tag, input beat_t bt, input exp_t e);
        drive(bt);
        dut_if.in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(dut_if.in_ready), 64'd1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, 64'(dut_if.out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_lat2_valid"}, 64'(dut_if.out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_after_valid"}, 64'(dut_if.out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: compare every transferred result against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!clear && dut_if.out_valid && dut_if.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(dut_if.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("out%0d_result", nout), 64'(dut_if.result), 64'(e.res));
                check($sformatf("out%0d_flags", nout),
                      64'({dut_if.overflow, dut_if.underflow, dut_if.invalid}),
                      64'({e.ovf, e.unf, e.inv}));
                nout++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t bt;
        beat_t beats[4];
        logic [31:0] held;
        int unsigned idx;

        clear            = 1'b1;
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("rst_result", 64'(dut_if.result), 64'd0);
        check("rst_flags", 64'({dut_if.overflow, dut_if.underflow, dut_if.invalid}), 64'd0);
        check("rst_in_ready", 64'(dut_if.in_ready), 64'd1);
        clear = 1'b0;

        beat_latency("mul_1p5x2", mk(1'b0, 32'h3FC00000, 32'h40000000, 48'h600000000000),
                     ex(1'b0, 1'b0, 1'b0, 32'h40400000));

        send(mk(1'b0, 32'h3F800001, 32'h3F800001, 48'h400001000001), ex(0, 0, 0, 32'h3F800002));
        send(mk(1'b0, 32'h7F000000, 32'h7F000000, 48'h400000000000), ex(1, 0, 0, 32'h7F800000));
        send(mk(1'b0, 32'h00800000, 32'h00800000, 48'h400000000000), ex(0, 1, 0, 32'h00000000));
        send(mk(1'b0, 32'h7F800000, 32'h00000000, 48'h0),            ex(0, 0, 1, 32'h7FC00000));
        send(mk(1'b0, 32'h7FC00000, 32'h3F800000, 48'h0),            ex(0, 0, 0, 32'h7FC00000));
        send(mk(1'b1, 32'hFF800000, 32'h40000000, 48'h0),            ex(0, 0, 0, 32'hFF800000));
        send(mk(1'b0, 32'h3F800000, 32'h3F800000, {1'b0, 24'h800002, 1'b1, 22'h0}), ex(0, 0, 0, 32'h3F800002));
        send(mk(1'b0, 32'h3F800000, 32'h3F800000, {1'b0, 24'h800003, 1'b1, 22'h0}), ex(0, 0, 0, 32'h3F800004));
        send(mk(1'b0, 32'h3F800000, 32'h3F800000, {1'b0, 24'h800000, 1'b1, 21'h0, 1'b1}), ex(0, 0, 0, 32'h3F800001));
        send(mk(1'b0, 32'h3F800000, 32'h3F800000, {24'hFFFFFF, 1'b1, 23'h0}), ex(0, 0, 0, 32'h40800000));
        send(mk(1'b0, 32'h3F800000, 32'h7F000000, {1'b0, 24'hFFFFFF, 1'b1, 22'h0}), ex(1, 0, 0, 32'h7F800000));
        send(mk(1'b0, 32'h3F800000, 32'h7F000000, 48'h400000000000), ex(0, 0, 0, 32'h7F000000));
        send(mk(1'b0, 32'h00800000, 32'h3F000000, 48'h400000000000), ex(0, 1, 0, 32'h00000000));
        send(mk(1'b0, 32'h00800000, 32'h3F800000, 48'h400000000000), ex(0, 0, 0, 32'h00800000));
        send(mk(1'b1, 32'h80000000, 32'h40000000, 48'h0),            ex(0, 0, 0, 32'h80000000));
        send(mk(1'b0, 32'h00000001, 32'h3F800000, 48'h0),            ex(0, 0, 0, 32'h00000000));
        for (int i = 0; i < 6; i++) begin
            bt = rand_beat();
            send(bt, model(bt));
        end
        drain();

        // Four back-to-back beats, consumer stalls for cycles 3..5.
        for (int i = 0; i < 4; i++) beats[i] = rand_beat();
        idx  = 0;
        held = '0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            dut_if.out_ready = !(cyc >= 3 && cyc <= 5);
            drive(beats[idx]);
            dut_if.in_valid = 1'b1;
            @(negedge clk);
            if (cyc >= 3 && cyc <= 5) begin
                check($sformatf("stall%0d_in_ready", cyc), 64'(dut_if.in_ready), 64'd0);
                check($sformatf("stall%0d_out_valid", cyc), 64'(dut_if.out_valid), 64'd1);
                if (cyc == 3) held = dut_if.result;
                else check($sformatf("stall%0d_result_held", cyc), 64'(dut_if.result), 64'(held));
            end
            if (dut_if.in_ready) begin
                sb.push_back(model(beats[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        check("stream_accepted", 64'(idx), 64'd4);
        drain();

        // Clear with two beats in flight.
        drive(mk(1'b0, 32'h40000000, 32'h40000000, 48'h400000000000));
        dut_if.in_valid = 1'b1;
        @(negedge clk);
        if (dut_if.in_ready) sb.push_back(ex(0, 0, 0, 32'h40800000));
        @(posedge clk);
        #1;
        drive(mk(1'b0, 32'h40400000, 32'h40000000, 48'h600000000000));
        @(negedge clk);
        if (dut_if.in_ready) sb.push_back(ex(0, 0, 0, 32'h40C00000));
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b0;
        check("preclear_out_valid", 64'(dut_if.out_valid), 64'd1);
        #1;
        clear = 1'b1;
        #1;
        check("clear_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("clear_result", 64'(dut_if.result), 64'd0);
        check("clear_flags", 64'({dut_if.overflow, dut_if.underflow, dut_if.invalid}), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("clear_hold_out_valid", 64'(dut_if.out_valid), 64'd0);
        clear = 1'b0;

        beat_latency("post_clear", mk(1'b1, 32'hBFC00000, 32'h40000000, 48'h600000000000),
                     ex(1'b0, 1'b0, 1'b0, 32'hC0400000));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
